// File: rtl/fetch_unit_if.sv
// Instruction-bus handshake between the fetch front end and memory.
// Request side is valid/addr; response side is addr_ok/data_ok/data.
interface fetch_unit_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch: one bus transaction per accepted PC,
// word held until decode takes it; misaligned PCs and bus hangs flagged.
module fetch_unit #(
  parameter int TIMEOUT = 1024,
  parameter int TIMER_W = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [31:0]  start_pc,
  input  logic         flush,
  output logic         busy,
  fetch_unit_if.master ibus,
  output logic         out_valid,
  output logic [31:0]  out_pc,
  output logic [31:0]  out_instr,
  output logic         out_err,
  input  logic         out_ready,
  output logic         timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_DEAD
  } state_e;

  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] T_MAX  = TIMER_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic               err_q, err_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  logic aok, dok, accept, last;

  assign aok  = ibus.iresp_addr_ok;
  assign dok  = ibus.iresp_data_ok;
  assign last = (timer_q == T_LAST);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    timer_d = timer_q;
    accept  = start & ~flush &
              ((state_q == S_IDLE) |
               ((state_q == S_HOLD) & out_ready));

    if ((state_q inside {S_REQ, S_WAIT, S_DRAIN}) &&
        (timer_q != T_MAX))
      timer_d = timer_q + 1'b1;

    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && (flush || out_ready))
          state_d = S_IDLE;
        if (accept) begin
          pc_d = start_pc;
          if (start_pc[1:0] == 2'b00) begin
            state_d = S_REQ;
            timer_d = '0;
            err_d   = 1'b0;
          end else begin
            state_d = S_HOLD;
            err_d   = 1'b1;
            instr_d = '0;
          end
        end
      end
      S_REQ: begin
        if (aok && dok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            instr_d = ibus.iresp_data;
            err_d   = 1'b0;
          end
        end else if (aok) begin
          state_d = flush ? S_DRAIN : S_WAIT;
        end else if (flush) begin
          state_d = S_IDLE;
        end
        if (last && !(aok && dok))
          state_d = S_DEAD;
      end
      S_WAIT: begin
        if (dok) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
            instr_d = ibus.iresp_data;
            err_d   = 1'b0;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
        if (last && !dok)
          state_d = S_DEAD;
      end
      // the owed data_ok is swallowed here; flush has nothing left to cancel
      S_DRAIN: begin
        if (dok)
          state_d = S_IDLE;
        else if (last)
          state_d = S_DEAD;
      end
      S_DEAD: state_d = S_DEAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign ibus.ireq_valid = (state_q == S_REQ);
  assign ibus.ireq_addr  = pc_q;
  assign out_valid       = (state_q == S_HOLD);
  assign out_pc          = pc_q;
  assign out_instr       = instr_q;
  assign out_err         = err_q;
  assign timeout         = (state_q == S_DEAD);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, timeout sequences,
// then random traffic against a transaction-level model.
module tb_fetch_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        st = 1'b0;
  logic [31:0] spc = '0;
  logic        fl = 1'b0;
  logic        rdy = 1'b0;
  logic        busy, out_valid, out_err, timeout;
  logic [31:0] out_pc, out_instr;
  int          nvec = 0;
  int          nmis = 0;
  bit          hang = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (st),
    .start_pc  (spc),
    .flush     (fl),
    .busy      (busy),
    .ibus      (bus),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_ready (rdy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Model: what the bus owes us and what decode is holding, not states.
  bit          m_req, m_owed, m_discard, m_hold, m_dead, m_err;
  logic [31:0] m_pc, m_instr;
  int          m_age;

  task automatic model_reset();
    m_req = 0; m_owed = 0; m_discard = 0; m_hold = 0; m_dead = 0;
    m_err = 0; m_pc = '0; m_instr = '0; m_age = 0;
  endtask

  task automatic model_step();
    bit ao, dk, done, free;
    ao = bus.iresp_addr_ok;
    dk = bus.iresp_data_ok;
    if (m_dead) begin
    end else if (m_req || m_owed) begin
      done = m_req ? (ao && dk) : dk;
      if (m_age == TO - 1 && !done) begin
        m_dead = 1; m_req = 0; m_owed = 0; m_hold = 0;
      end else if (m_req) begin
        m_req = 0;
        if (ao && dk) begin
          if (!fl) begin
            m_hold = 1; m_instr = bus.iresp_data; m_err = 0;
          end
        end else if (ao) begin
          m_owed = 1; m_discard = fl;
        end else if (!fl) begin
          m_req = 1;
        end
      end else begin
        if (dk) begin
          if (!m_discard && !fl) begin
            m_hold = 1; m_instr = bus.iresp_data; m_err = 0;
          end
          m_owed = 0; m_discard = 0;
        end else if (fl) begin
          m_discard = 1;
        end
      end
      m_age++;
    end else begin
      free = !m_hold || rdy;
      if (m_hold && (fl || rdy)) m_hold = 0;
      if (st && !fl && free) begin
        m_pc = spc;
        if (spc[1:0] == 2'b00) begin
          m_req = 1; m_age = 0; m_err = 0;
        end else begin
          m_hold = 1; m_err = 1; m_instr = '0;
        end
      end
    end
  endtask

  function automatic logic [100:0] model_out();
    return {m_req | m_owed | m_hold | m_dead, m_req, m_hold, m_err,
            m_dead, m_pc, m_pc, m_instr};
  endfunction

  function automatic logic [100:0] dut_out();
    return {busy, bus.ireq_valid, out_valid, out_err, timeout,
            bus.ireq_addr, out_pc, out_instr};
  endfunction

  task automatic cmp(string nm, logic [100:0] got, logic [100:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic drive(logic s, logic [31:0] p, logic f, logic a,
                       logic d, logic [31:0] w, logic r);
    st = s; spc = p; fl = f; rdy = r;
    bus.iresp_addr_ok = a; bus.iresp_data_ok = d; bus.iresp_data = w;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    cmp("reset", dut_out(), 101'd0);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic s, f, a, d, r;
    logic [31:0] p, w;
    logic eb, erv, eov, eerr;
    logic [31:0] ea, ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic s, logic [31:0] p, logic f, logic a,
                             logic d, logic [31:0] w, logic r,
                             logic [3:0] e, logic [31:0] ea,
                             logic [31:0] ei);
    vec_t x;
    x.s = s; x.p = p; x.f = f; x.a = a; x.d = d; x.w = w; x.r = r;
    {x.eb, x.erv, x.eov, x.eerr} = e;
    x.ea = ea; x.ei = ei;
    return x;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // e = {busy, ireq_valid, out_valid, out_err}
    tbl.push_back(v(1, 32'hBFC00000, 0, 0, 0, 0, 0, 4'b1100, 32'hBFC00000, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h12345678, 0, 4'b1010, 32'hBFC00000, 32'h12345678));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0000, 32'hBFC00000, 32'h12345678));
    tbl.push_back(v(1, 32'h00400000, 0, 0, 0, 0, 0, 4'b1100, 32'h00400000, 32'h12345678));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 4'b1100, 32'h00400000, 32'h12345678));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 4'b1000, 32'h00400000, 32'h12345678));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'b1000, 32'h00400000, 32'h12345678));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 4'b1010, 32'h00400000, 32'hDEADBEEF));
    tbl.push_back(v(1, 32'h00400004, 0, 0, 0, 0, 1, 4'b1100, 32'h00400004, 32'hDEADBEEF));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'h00000013, 0, 4'b1010, 32'h00400004, 32'h00000013));
    tbl.push_back(v(1, 32'h00400002, 0, 0, 0, 0, 1, 4'b1011, 32'h00400002, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0001, 32'h00400002, 0));
    tbl.push_back(v(1, 32'h00400003, 0, 0, 0, 0, 0, 4'b1011, 32'h00400003, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 4'b0001, 32'h00400003, 0));
    tbl.push_back(v(1, 32'h00400010, 0, 0, 0, 0, 0, 4'b1100, 32'h00400010, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 4'b1000, 32'h00400010, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'b1000, 32'h00400010, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'b1000, 32'h00400010, 0));
    tbl.push_back(v(1, 32'h00400014, 1, 0, 0, 0, 1, 4'b1000, 32'h00400010, 0));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 4'b1000, 32'h00400010, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 4'b0000, 32'h00400010, 0));
    tbl.push_back(v(1, 32'h00400020, 0, 0, 0, 0, 0, 4'b1100, 32'h00400020, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 4'b0000, 32'h00400020, 0));
    tbl.push_back(v(1, 32'h00400040, 1, 0, 0, 0, 0, 4'b0000, 32'h00400020, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h11111111, 0, 4'b0000, 32'h00400020, 0));
    tbl.push_back(v(1, 32'h00400030, 0, 0, 0, 0, 0, 4'b1100, 32'h00400030, 0));
    tbl.push_back(v(0, 0, 0, 1, 1, 32'hAAAA5555, 0, 4'b1010, 32'h00400030, 32'hAAAA5555));
    tbl.push_back(v(1, 32'h00400034, 0, 0, 0, 0, 0, 4'b1010, 32'h00400030, 32'hAAAA5555));
    tbl.push_back(v(1, 32'h00400038, 1, 0, 0, 0, 1, 4'b0000, 32'h00400030, 32'hAAAA5555));
    tbl.push_back(v(1, 32'h00400040, 0, 0, 0, 0, 0, 4'b1100, 32'h00400040, 32'hAAAA5555));
    tbl.push_back(v(0, 0, 1, 1, 1, 32'h22222222, 0, 4'b0000, 32'h00400040, 32'hAAAA5555));
    tbl.push_back(v(1, 32'h00400044, 0, 0, 0, 0, 0, 4'b1100, 32'h00400044, 32'hAAAA5555));
    tbl.push_back(v(0, 0, 1, 1, 0, 0, 0, 4'b1000, 32'h00400044, 32'hAAAA5555));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h00000003, 0, 4'b0000, 32'h00400044, 32'hAAAA5555));

    #2;
    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].p, tbl[i].f, tbl[i].a, tbl[i].d,
            tbl[i].w, tbl[i].r);
      tick();
      cmp($sformatf("vec%0d", i), dut_out(),
          {tbl[i].eb, tbl[i].erv, tbl[i].eov, tbl[i].eerr, 1'b0,
           tbl[i].ea, tbl[i].ea, tbl[i].ei});
    end

    // bus hang: address taken, data never returned
    do_reset();
    drive(1, 32'h00000100, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (14) tick();
    cmp("pre_timeout", 101'({busy, bus.ireq_valid, out_valid, timeout}),
        101'(4'b1000));
    tick();
    cmp("timeout", 101'({busy, bus.ireq_valid, out_valid, timeout}),
        101'(4'b1001));
    drive(1, 32'h00000200, 1, 1, 1, 32'h77, 1);
    repeat (3) tick();
    cmp("timeout_sticky", 101'({busy, bus.ireq_valid, out_valid, timeout}),
        101'(4'b1001));
    drive(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // data arriving on the very last allowed cycle still completes
    drive(1, 32'h00000300, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (14) tick();
    drive(0, 0, 0, 0, 1, 32'h00000055, 0);
    tick();
    cmp("last_cycle_data", dut_out(),
        {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h300, 32'h300, 32'h55});

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      if ($urandom_range(59) == 0) hang = !hang;
      p = $urandom;
      if ($urandom_range(6) != 0) p[1:0] = 2'b00;
      drive($urandom_range(1) == 1, p, $urandom_range(9) == 0,
            $urandom_range(4) < 2,
            !hang && ($urandom_range(2) == 0),
            $urandom, $urandom_range(1) == 1);
      tick();
      cmp("rand", dut_out(), model_out());
      if ((m_dead && $urandom_range(3) == 0) || $urandom_range(299) == 0)
        do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
